// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_pkg
//  Description : Shared types and constants for the sequential binary neuron.
//                Holds the controller state encoding and the chunk and
//                popcount widths used by the top level and popcount units.
//  Revision    : 1.0 - initial release
// ============================================================================
package neuron_pkg;

  // Bits in one input chunk, and bits needed to count 0..25.
  localparam int CHUNK_W = 25;
  localparam int PC_W    = 5;

  // Evaluation controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

endpackage : neuron_pkg
`default_nettype wire

// File: rtl/popcount25_exact.sv
`default_nettype none
// ============================================================================
//  Module      : popcount25_exact
//  Description : Exact combinational population count of a 25-bit vector.
//                Port shape is shared with the approximate popcount25
//                variants so one can be swapped for another.
//  Ports       : i_bits  [24:0]  input vector
//                o_count [4:0]   number of ones in i_bits (0..25)
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount25_exact
  import neuron_pkg::*;
(
  input  logic [CHUNK_W-1:0] i_bits,
  output logic [PC_W-1:0]    o_count
);

  // Five 5-bit groups are counted first (0..5, 3 bits each); the group
  // counts are then summed. Keeps the adder chain short and balanced.
  logic [2:0] w_grp [5];

  always_comb begin
    for (int g = 0; g < 5; g++) begin
      w_grp[g] = 3'd0;
      for (int b = 0; b < 5; b++) begin
        w_grp[g] = w_grp[g] + 3'(i_bits[g*5 + b]);
      end
    end
  end

  always_comb begin
    o_count = '0;
    for (int g = 0; g < 5; g++) begin
      o_count = o_count + PC_W'(w_grp[g]);
    end
  end

endmodule : popcount25_exact
`default_nettype wire

// File: rtl/popcount25_neuron_seq.sv
`default_nettype none
// ============================================================================
//  Module      : popcount25_neuron_seq
//  Description : Sequential binary neuron. Accepts a stream of 25-bit chunks
//                of +1 / -1 match masks, accumulates
//                popcount(pos) - popcount(neg) over the evaluation in a
//                two-stage pipeline, and presents the signed sum, a fire
//                flag (sum >= threshold) and an overrun flag.
//  Config      : NEURON_SEQ_SATURATE_EN - when defined the accumulator
//                clamps to the signed ACC_W range on every add; otherwise it
//                wraps modulo 2^ACC_W.
//  Ports       : clk, rst_n            clock, synchronous active-low reset
//                in_valid/in_ready     chunk handshake
//                in_pos/in_neg [24:0]  +1 / -1 match masks of one chunk
//                in_last               final chunk of the evaluation
//                thr [ACC_W]           signed threshold (first chunk)
//                out_valid/out_ready   result handshake
//                out_acc [ACC_W]       signed sum
//                out_fire              out_acc >= threshold
//                out_err               evaluation ran out of chunk slots
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount25_neuron_seq
  import neuron_pkg::*;
#(
  parameter int MAX_CHUNKS = 8,
  parameter int ACC_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CHUNK_W-1:0]      in_pos,
  input  logic [CHUNK_W-1:0]      in_neg,
  input  logic                    in_last,
  input  logic signed [ACC_W-1:0] thr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_fire,
  output logic                    out_err
);

  localparam int CNT_W = $clog2(MAX_CHUNKS + 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                  r_state;
  logic                    r_in_ready;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_thr;
  logic                    r_out_valid;
  logic                    r_out_fire;
  logic                    r_out_err;

  // Stage 1 pipeline register
  logic                    r_s1_valid;
  logic                    r_s1_last;
  logic                    r_s1_err;
  logic [PC_W-1:0]         r_pc_pos;
  logic [PC_W-1:0]         r_pc_neg;

  // --------------------------------------------------------------------------
  // Popcounts of the incoming chunk
  // --------------------------------------------------------------------------
  logic [PC_W-1:0] w_pc_pos;
  logic [PC_W-1:0] w_pc_neg;

  popcount25_exact u_pc_pos (
    .i_bits  (in_pos),
    .o_count (w_pc_pos)
  );

  popcount25_exact u_pc_neg (
    .i_bits  (in_neg),
    .o_count (w_pc_neg)
  );

  // --------------------------------------------------------------------------
  // Chunk acceptance and overrun detection
  // --------------------------------------------------------------------------
  logic             w_xfer;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_full;
  logic             w_eff_last;
  logic             w_overrun;

  // in_ready is a register, so the transfer condition never depends
  // combinationally on out_ready.
  assign w_xfer     = in_valid && r_in_ready;
  assign w_cnt_nxt  = (r_state == ST_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
  assign w_full     = (w_cnt_nxt == CNT_W'(MAX_CHUNKS));
  // The chunk filling the last slot closes the evaluation even without
  // in_last; that case is flagged as an overrun.
  assign w_eff_last = in_last || w_full;
  assign w_overrun  = w_full && !in_last;

  // --------------------------------------------------------------------------
  // Stage 2 arithmetic
  // --------------------------------------------------------------------------
  logic [PC_W:0]           w_delta6;
  logic signed [ACC_W-1:0] w_delta;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic                    w_fire;

  // Difference of two 0..25 counts fits in a 6-bit signed value.
  assign w_delta6 = {1'b0, r_pc_pos} - {1'b0, r_pc_neg};
  assign w_delta  = ACC_W'($signed(w_delta6));

`ifdef NEURON_SEQ_SATURATE_EN
  // One extra bit catches overflow; a differing top pair means the true
  // sum left the ACC_W range and is clamped toward its sign.
  logic signed [ACC_W:0] w_sum;
  assign w_sum = {r_acc[ACC_W-1], r_acc} + {w_delta[ACC_W-1], w_delta};

  always_comb begin
    w_acc_nxt = w_sum[ACC_W-1:0];
    if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
      w_acc_nxt = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                               : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign w_acc_nxt = r_acc + w_delta;
`endif

  assign w_fire = (w_acc_nxt >= r_thr);

  // --------------------------------------------------------------------------
  // Controller, pipeline and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_thr       <= '0;
      r_out_valid <= 1'b0;
      r_out_fire  <= 1'b0;
      r_out_err   <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_err    <= 1'b0;
      r_pc_pos    <= '0;
      r_pc_neg    <= '0;
    end else begin
      // Stage 1 captures every accepted chunk.
      r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_pc_pos  <= w_pc_pos;
        r_pc_neg  <= w_pc_neg;
        r_s1_last <= w_eff_last;
        r_s1_err  <= w_overrun;
      end

      // Stage 2 folds the previous chunk into the accumulator. In IDLE no
      // chunk is in flight, so clearing and adding never collide.
      if (r_s1_valid) begin
        r_acc <= w_acc_nxt;
      end

      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_xfer) begin
            r_acc <= '0;
            r_thr <= thr;
            r_cnt <= w_cnt_nxt;
            if (w_eff_last) begin
              r_state    <= ST_DRAIN;
              r_in_ready <= 1'b0;
            end else begin
              r_state <= ST_ACCUM;
            end
          end
        end

        ST_ACCUM: begin
          if (w_xfer) begin
            r_cnt <= w_cnt_nxt;
            if (w_eff_last) begin
              r_state    <= ST_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end

        ST_DRAIN: begin
          // The closing chunk sits in stage 1 for exactly this cycle.
          if (r_s1_valid && r_s1_last) begin
            r_state     <= ST_RESULT;
            r_out_valid <= 1'b1;
            r_out_fire  <= w_fire;
            r_out_err   <= r_s1_err;
          end
        end

        ST_RESULT: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_acc   = r_acc;
  assign out_fire  = r_out_fire;
  assign out_err   = r_out_err;

endmodule : popcount25_neuron_seq
`default_nettype wire

// File: tb/tb_popcount25_neuron_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_popcount25_neuron_seq
//  Description : Directed self-checking bench for popcount25_neuron_seq.
//                Inputs change and outputs are sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_popcount25_neuron_seq;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [24:0]       in_pos;
  logic [24:0]       in_neg;
  logic              in_last;
  logic signed [7:0] thr;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_acc;
  logic              out_fire;
  logic              out_err;

  int n_vec = 0;
  int n_err = 0;

  popcount25_neuron_seq #(
    .MAX_CHUNKS (8),
    .ACC_W      (8)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pos    (in_pos),
    .in_neg    (in_neg),
    .in_last   (in_last),
    .thr       (thr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_fire  (out_fire),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] ones(input int n);
    logic [31:0] v;
    v = (32'd1 << n) - 32'd1;
    return v[24:0];
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; presents one chunk, checks it is acceptable,
  // and returns on the next falling edge with in_valid dropped.
  task automatic drive_chunk(input string tag, input int np, input int nn,
                             input logic last, input int t);
    in_valid = 1'b1;
    in_pos   = ones(np);
    in_neg   = ones(nn);
    in_last  = last;
    thr      = 8'(t);
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called one cycle after the closing chunk: result must not be out yet,
  // and must appear exactly on the following cycle.
  task automatic expect_result(input string tag, input int acc, input int fire, input int err);
    chk({tag, "_valid_early"}, out_valid, 0);
    chk({tag, "_in_ready_drain"}, in_ready, 0);
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_acc"}, $signed(out_acc), acc);
    chk({tag, "_fire"}, out_fire, fire);
    chk({tag, "_err"}, out_err, err);
  endtask

  task automatic accept_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_after_hs"}, out_valid, 0);
    chk({tag, "_in_ready_after_hs"}, in_ready, 1);
  endtask

  int held_acc;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pos    = '0;
    in_neg    = '0;
    in_last   = 1'b0;
    thr       = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_acc", $signed(out_acc), 0);
    chk("rst_fire", out_fire, 0);
    chk("rst_err", out_err, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Single full chunk: 25 - 0 = 25 >= 20
    drive_chunk("one", 25, 0, 1'b1, 20);
    expect_result("one", 25, 1, 0);
    accept_result("one");

    // Three back-to-back chunks: +7, -12, 0 -> -5 >= -5. Later thr values
    // must be ignored since the threshold is taken from the first chunk.
    drive_chunk("b2b0", 10, 3, 1'b0, -5);
    drive_chunk("b2b1", 0, 12, 1'b0, 100);
    drive_chunk("b2b2", 5, 5, 1'b1, 100);
    expect_result("b2b", -5, 1, 0);
    accept_result("b2b");

    // Stall mid-evaluation: +20, gap, -4 -> 16 < 17
    drive_chunk("stall0", 20, 0, 1'b0, 17);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", out_valid, 0);
      chk("stall_in_ready", in_ready, 1);
      @(negedge clk);
    end
    drive_chunk("stall1", 0, 4, 1'b1, -100);
    expect_result("stall", 16, 0, 0);
    accept_result("stall");

    // Overrun: eight chunks of +25 without in_last. 200 wraps to -56,
    // saturation pins it at 127.
    for (int i = 0; i < 8; i++) begin
      drive_chunk("ovr", 25, 0, 1'b0, 0);
    end
`ifdef NEURON_SEQ_SATURATE_EN
    expect_result("ovr", 127, 1, 1);
`else
    expect_result("ovr", -56, 0, 1);
`endif

    // Hold the result with out_ready low while a new chunk waits.
    held_acc  = int'($signed(out_acc));
    in_valid  = 1'b1;
    in_pos    = ones(3);
    in_neg    = ones(1);
    in_last   = 1'b1;
    thr       = 8'sd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_acc", $signed(out_acc), held_acc);
      chk("hold_err", out_err, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold_valid_after_hs", out_valid, 0);
    drive_chunk("after_hold", 3, 1, 1'b1, 2);
    expect_result("after_hold", 2, 1, 0);
    accept_result("after_hold");

    // Reset after two of four chunks discards the evaluation.
    drive_chunk("rst_mid0", 5, 0, 1'b0, 0);
    drive_chunk("rst_mid1", 5, 0, 1'b0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_acc", $signed(out_acc), 0);
    chk("rst_mid_fire", out_fire, 0);
    chk("rst_mid_err", out_err, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    @(negedge clk);
    chk("rst_mid_valid_idle", out_valid, 0);
    drive_chunk("post_rst", 7, 0, 1'b1, 0);
    expect_result("post_rst", 7, 1, 0);
    accept_result("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_popcount25_neuron_seq
`default_nettype wire

// File: doc/popcount25_neuron_seq.md
POPCOUNT25_NEURON_SEQ -- requirements
Module: popcount25_neuron_seq

Interface
REQ-001 SHALL have parameter MAX_CHUNKS, default 8, maximum number of 25-bit chunks per neuron evaluation.
REQ-002 SHALL have parameter ACC_W, default 8, signed accumulator/threshold width in bits.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1: chunk handshake, transfer when both high.
REQ-006 SHALL have ports in_pos input 25 and in_neg input 25: +1 / -1 weight-activation match masks for one chunk.
REQ-007 SHALL have port in_last  input  1  marks final chunk of the evaluation.
REQ-008 SHALL have port thr  input  ACC_W  signed firing threshold, sampled on first accepted chunk of an evaluation.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1: result handshake.
REQ-010 SHALL have ports out_acc output ACC_W (signed sum), out_fire output 1 (out_acc >= threshold, signed) and out_err output 1 (overrun flag).

Function
REQ-011 SHALL run FSM IDLE, ACCUM, DRAIN, RESULT; in_ready high only in IDLE and ACCUM.
REQ-012 IDLE: on chunk transfer SHALL clear accumulator, latch thr, set chunk count to 1, go to ACCUM (or DRAIN if chunk is last).
REQ-013 Stage 1 SHALL register popcount(in_pos) and popcount(in_neg) (5 bits each) in the cycle after transfer.
REQ-014 Stage 2 SHALL add (pc_pos - pc_neg), sign-extended to ACC_W, into accumulator one cycle after stage 1.
REQ-015 Latency: last chunk accepted at cycle t SHALL give out_valid high at cycle t+2; back-to-back chunks SHALL be accepted every cycle in ACCUM.
REQ-016 ACCUM: on last-chunk transfer SHALL go to DRAIN; DRAIN SHALL last exactly until stage 2 of last chunk completes, then enter RESULT.
REQ-017 Overrun: if the MAX_CHUNKS-th chunk arrives with in_last=0, SHALL treat it as last and set out_err=1 for that result.
REQ-018 RESULT: out_valid, out_acc, out_fire, out_err SHALL hold stable until out_ready; on out_valid&&out_ready SHALL go to IDLE, with in_ready high in the next cycle.
REQ-019 out_valid high with out_ready high in same cycle SHALL complete in that cycle; no combinational path from out_ready to in_ready.
REQ-020 in_valid low mid-evaluation SHALL stall ACCUM indefinitely with no state change beyond pipeline drain.

Reset
REQ-021 With rst_n low at a clock edge, SHALL enter IDLE, clear accumulator, count, pipeline valids, out_valid=0, out_acc=0, out_fire=0, out_err=0, in_ready=0 during reset cycle, 1 after.
REQ-022 Reset mid-evaluation or in RESULT SHALL discard in-flight chunks and the pending result.

Configuration
REQ-023 Macro NEURON_SEQ_SATURATE_EN defined: accumulator SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] on each add.
REQ-024 Macro NEURON_SEQ_SATURATE_EN undefined: accumulator SHALL wrap two's-complement modulo 2^ACC_W.

Structure
REQ-025 Shared package neuron_pkg SHALL hold FSM state enum, PC_W=5 and CHUNK_W=25 constants.
REQ-026 Popcount SHALL be a sub-module popcount25_exact (25-in, 5-out, combinational), instantiated twice; interface-compatible with the team's approximate popcount25 variants for later substitution.

Verification
REQ-027 One chunk in_pos=0x1FFFFFF, in_neg=0, thr=20, last=1 at t -> out_valid at t+2, out_acc=25, out_fire=1, out_err=0.
REQ-028 Three back-to-back chunks pos/neg counts (10,3),(0,12),(5,5), thr=-5 -> out_acc=-5, out_fire=1, in_ready high all three cycles.
REQ-029 Eight chunks all pos=0x1FFFFFF, neg=0, none last -> result after 8th, out_err=1; out_acc=127 with NEURON_SEQ_SATURATE_EN, 200 mod 256 = -56 without.
REQ-030 Result with out_ready low 5 cycles -> outputs stable, in_ready low, new chunk accepted only cycle after handshake.
REQ-031 rst_n low for 1 cycle after 2 of 4 chunks -> IDLE, outputs zero, next 1-chunk evaluation pos count 7 gives out_acc=7.
